// File: rtl/extensor_imediato_pipe_pkg.sv
// Shared definitions for the pipelined immediate extender: mode encoding
// and the default input/output widths of the MIPS datapath.
package pacote_extensor;

    // Extension modes selected by the decode stage.
    typedef enum logic [1:0] {
        MODO_ZERO     = 2'd0,   // zero-extend
        MODO_SINAL    = 2'd1,   // sign-extend
        MODO_SUPERIOR = 2'd2,   // immediate in the upper bits (lui)
        MODO_DESVIO   = 2'd3    // sign-extend, then word offset (<< 2)
    } modo_t;

    // Default widths: 16-bit instruction immediate to 32-bit operand.
    localparam int LARG_ENT = 16;
    localparam int LARG_SAI = 32;

endpackage : pacote_extensor

// File: rtl/extensor_imediato_pipe_fila_sincrona.sv
// Small synchronous FIFO with a combinational head read. The head entry is
// visible the cycle after it is written, with no fall-through from the
// write port. Pushes while full and pops while empty are ignored, so the
// block stays consistent even if a caller forgets to gate them.
module fila_sincrona #(
    parameter int LARGURA      = 32,
    parameter int PROFUNDIDADE = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dado_ent,
    output logic [LARGURA-1:0] dado_sai,
    output logic               cheia,
    output logic               vazia
);

    // Depth is a power of two, so pointers wrap by plain overflow.
    localparam int LARG_PTR  = $clog2(PROFUNDIDADE);
    localparam int LARG_OCUP = LARG_PTR + 1;

    logic [LARGURA-1:0]   mem_reg [PROFUNDIDADE];
    logic [LARG_PTR-1:0]  wr_ptr_reg,   wr_ptr_next;
    logic [LARG_PTR-1:0]  rd_ptr_reg,   rd_ptr_next;
    logic [LARG_OCUP-1:0] ocupacao_reg, ocupacao_next;
    logic                 push_ok;
    logic                 pop_ok;

    assign cheia   = (ocupacao_reg == LARG_OCUP'(PROFUNDIDADE));
    assign vazia   = (ocupacao_reg == '0);
    assign push_ok = push && !cheia;
    assign pop_ok  = pop && !vazia;

    // One write-enabled register per entry; only the tail slot loads.
    // Data storage is not reset: occupancy alone decides what is valid.
    generate
        for (genvar gi = 0; gi < PROFUNDIDADE; gi++) begin : g_entrada
            always_ff @(posedge clock) begin
                if (push_ok && (wr_ptr_reg == LARG_PTR'(gi))) begin
                    mem_reg[gi] <= dado_ent;
                end
            end
        end
    endgenerate

    // Head of the queue, read directly from storage.
    assign dado_sai = mem_reg[rd_ptr_reg];

    // Next-state for pointers and occupancy; simultaneous push and pop
    // leave occupancy unchanged.
    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        ocupacao_next = ocupacao_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + LARG_PTR'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + LARG_PTR'(1);
        end
        if (push_ok && !pop_ok) begin
            ocupacao_next = ocupacao_reg + LARG_OCUP'(1);
        end else if (pop_ok && !push_ok) begin
            ocupacao_next = ocupacao_reg - LARG_OCUP'(1);
        end
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ocupacao_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            ocupacao_reg <= ocupacao_next;
        end
    end

endmodule : fila_sincrona

// File: rtl/extensor_imediato_pipe.sv
// Pipelined immediate extender. The immediate is extended combinationally
// in the accepting cycle and stored in a small FIFO, so the decode stage
// and the ALU operand stage can stall independently. The output is always
// taken from registered FIFO state: there is no path from input to output.
module extensor_imediato_pipe #(
    parameter int LARG_ENT     = pacote_extensor::LARG_ENT,
    parameter int LARG_SAI     = pacote_extensor::LARG_SAI,
    parameter int PROFUNDIDADE = 2,
    parameter int LARG_CONT    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ent_valida,
    output logic                 ent_pronto,
    input  logic [1:0]           modo,
    input  logic [LARG_ENT-1:0]  extensorS,
    output logic                 sai_valida,
    input  logic                 sai_pronto,
    output logic [LARG_SAI-1:0]  saidaExtensor,
    output logic [LARG_CONT-1:0] contador_ext
);

    import pacote_extensor::*;

    localparam int LARG_PAD = LARG_SAI - LARG_ENT;

    logic [LARG_SAI-1:0]  ext_sinal;
    logic [LARG_SAI-1:0]  ext_comb;
    logic [LARG_SAI-1:0]  cabeca;
    logic                 cheia;
    logic                 vazia;
    logic                 push;
    logic                 pop;
    logic [LARG_CONT-1:0] contador_reg;

    // Extension function: sign-extended value is shared by SINAL and
    // DESVIO; SUPERIOR drops any immediate bits shifted past the top.
    always_comb begin
        ext_sinal = {{LARG_PAD{extensorS[LARG_ENT-1]}}, extensorS};
        ext_comb  = '0;
        case (modo_t'(modo))
            MODO_ZERO:     ext_comb = {{LARG_PAD{1'b0}}, extensorS};
            MODO_SINAL:    ext_comb = ext_sinal;
            MODO_SUPERIOR: ext_comb = {{LARG_PAD{1'b0}}, extensorS} << LARG_PAD;
            MODO_DESVIO:   ext_comb = ext_sinal << 2;
            default:       ext_comb = '0;
        endcase
    end

    // Handshake: readiness depends only on FIFO state, never on sai_pronto.
    assign ent_pronto = !cheia;
    assign sai_valida = !vazia;
    assign push       = ent_valida && ent_pronto;
    assign pop        = sai_valida && sai_pronto;

    fila_sincrona #(
        .LARGURA      (LARG_SAI),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .dado_ent (ext_comb),
        .dado_sai (cabeca),
        .cheia    (cheia),
        .vazia    (vazia)
    );

    // Stale storage never leaks out: the output is forced to 0 when empty.
    assign saidaExtensor = vazia ? '0 : cabeca;

    // Count completed output transfers; wraps silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_reg <= '0;
        end else if (pop) begin
            contador_reg <= contador_reg + LARG_CONT'(1);
        end
    end

    assign contador_ext = contador_reg;

endmodule : extensor_imediato_pipe

// File: tb/tb_extensor_imediato_pipe.sv
// Self-checking bench for extensor_imediato_pipe. A queue-based reference
// model tracks FIFO contents and the transfer count; expected extension
// results are computed with plain integer arithmetic.
module tb_extensor_imediato_pipe;

    localparam int PROF  = 2;
    localparam int LCONT = 4;   // narrow counter so wrap-around is reached

    typedef struct {
        logic [1:0]  m;
        logic [15:0] x;
    } entrada_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ent_valida = 1'b0;
    logic        ent_pronto;
    logic [1:0]  modo = 2'd0;
    logic [15:0] extensorS = 16'h0;
    logic        sai_valida;
    logic        sai_pronto = 1'b0;
    logic [31:0] saidaExtensor;
    logic [LCONT-1:0] contador_ext;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_q[$];      // expected FIFO contents, head first
    entrada_t    pend[$];       // producer's queue of inputs to offer
    int unsigned mdl_cont = 0;  // expected completed transfers (mod 2^LCONT)

    extensor_imediato_pipe #(
        .LARG_ENT     (16),
        .LARG_SAI     (32),
        .PROFUNDIDADE (PROF),
        .LARG_CONT    (LCONT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ent_valida    (ent_valida),
        .ent_pronto    (ent_pronto),
        .modo          (modo),
        .extensorS     (extensorS),
        .sai_valida    (sai_valida),
        .sai_pronto    (sai_pronto),
        .saidaExtensor (saidaExtensor),
        .contador_ext  (contador_ext)
    );

    always #5 clock = ~clock;

    // Reference extension from the arithmetic definition of each mode.
    function automatic logic [31:0] ext_ref(input logic [1:0] m, input logic [15:0] x);
        longint unsigned v;
        longint unsigned s;
        longint unsigned r;
        v = longint'(x);
        s = (x >= 16'h8000) ? (v + 64'd4294901760) : v;  // x - 2^16 mod 2^32
        case (m)
            2'd0:    r = v;
            2'd1:    r = s;
            2'd2:    r = (v * 64'd65536) % 64'd4294967296;
            default: r = (s * 64'd4) % 64'd4294967296;
        endcase
        return r[31:0];
    endfunction

    // Put the producer's head item (or idle random data) on the inputs.
    task automatic drive_inputs();
        if (pend.size() > 0) begin
            ent_valida = 1'b1;
            modo       = pend[0].m;
            extensorS  = pend[0].x;
        end else begin
            ent_valida = 1'b0;
            modo       = 2'($urandom_range(3));
            extensorS  = 16'($urandom);
        end
    endtask

    // Advance one clock, update the model, and compare every output.
    task automatic step();
        bit          do_push;
        bit          do_pop;
        logic [31:0] novo;
        do_push = ent_valida && (mdl_q.size() < PROF);
        do_pop  = (mdl_q.size() > 0) && sai_pronto;
        novo    = ext_ref(modo, extensorS);
        @(posedge clock);
        #1;
        if (reset) begin
            mdl_q.delete();
            mdl_cont = 0;
        end else begin
            if (do_pop) begin
                $display("out xfer n=%0d data=%08h", mdl_cont + 1, mdl_q[0]);
                void'(mdl_q.pop_front());
                mdl_cont = (mdl_cont + 1) % (1 << LCONT);
            end
            if (do_push) begin
                mdl_q.push_back(novo);
                void'(pend.pop_front());
            end
        end
        drive_inputs();
        checks++;
        if (sai_valida !== (mdl_q.size() > 0)) begin
            failures++;
            $display("FAIL model_sai_valida got=%b exp=%b", sai_valida, mdl_q.size() > 0);
        end
        checks++;
        if (saidaExtensor !== ((mdl_q.size() > 0) ? mdl_q[0] : 32'h0)) begin
            failures++;
            $display("FAIL model_saida got=%08h exp=%08h", saidaExtensor,
                     (mdl_q.size() > 0) ? mdl_q[0] : 32'h0);
        end
        checks++;
        if (ent_pronto !== (mdl_q.size() < PROF)) begin
            failures++;
            $display("FAIL model_ent_pronto got=%b exp=%b", ent_pronto, mdl_q.size() < PROF);
        end
        checks++;
        if (contador_ext !== LCONT'(mdl_cont)) begin
            failures++;
            $display("FAIL model_contador got=%0d exp=%0d", contador_ext, mdl_cont);
        end
    endtask

    // Run until producer and FIFO are empty, bounded by a cycle budget.
    task automatic drain(input string nome);
        int n;
        n = 0;
        sai_pronto = 1'b1;
        while ((pend.size() > 0 || mdl_q.size() > 0) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (pend.size() > 0 || mdl_q.size() > 0) begin
            failures++;
            $display("FAIL %s_drain_timeout got=pend%0d/fifo%0d exp=0/0", nome, pend.size(), mdl_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pend.delete();
        drive_inputs();
        step();
        step();
        checks++;
        if (sai_valida !== 1'b0 || saidaExtensor !== 32'h0 || ent_pronto !== 1'b1 || contador_ext !== '0) begin
            failures++;
            $display("FAIL reset_state got=v%b d%08h r%b c%0d exp=v0 d00000000 r1 c0",
                     sai_valida, saidaExtensor, ent_pronto, contador_ext);
        end
        reset = 1'b0;
        step();
    endtask

    // Directed vectors with literal expected values, one input at a time.
    task automatic test_modes();
        logic [1:0]  vm [8] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        logic [15:0] vx [8] = '{16'h8001, 16'h7FFF, 16'h8001, 16'h1234,
                               16'hFFFF, 16'h0004, 16'h8000, 16'hFFFF};
        logic [31:0] ve [8] = '{32'hFFFF8001, 32'h00007FFF, 32'h00008001, 32'h12340000,
                               32'hFFFFFFFC, 32'h00000010, 32'hFFFE0000, 32'h0000FFFF};
        for (int i = 0; i < 8; i++) begin
            sai_pronto = 1'b1;
            pend.push_back('{vm[i], vx[i]});
            drive_inputs();
            step();  // accepting edge; result visible right after it
            checks++;
            if (sai_valida !== 1'b1 || saidaExtensor !== ve[i]) begin
                failures++;
                $display("FAIL modes_%0d got=v%b %08h exp=v1 %08h", i, sai_valida, saidaExtensor, ve[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] esperado;
        int c0;
        c0 = int'(contador_ext);
        sai_pronto = 1'b0;
        for (int i = 1; i <= 3; i++) pend.push_back('{2'd1, 16'(i)});
        drive_inputs();
        step();
        step();
        step();
        checks++;
        if (ent_pronto !== 1'b0 || pend.size() != 1 || saidaExtensor !== 32'h1) begin
            failures++;
            $display("FAIL backpressure_full got=r%b held%0d head%08h exp=r0 held1 head00000001",
                     ent_pronto, pend.size(), saidaExtensor);
        end
        sai_pronto = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            esperado = 32'(i);
            checks++;
            if (sai_valida !== 1'b1 || saidaExtensor !== esperado) begin
                failures++;
                $display("FAIL backpressure_order_%0d got=v%b %08h exp=v1 %08h", i, sai_valida, saidaExtensor, esperado);
            end
            step();
        end
        checks++;
        if (int'(contador_ext) != (c0 + 3) % (1 << LCONT)) begin
            failures++;
            $display("FAIL backpressure_count got=%0d exp=%0d", contador_ext, (c0 + 3) % (1 << LCONT));
        end
    endtask

    task automatic test_full_simultaneous();
        sai_pronto = 1'b0;
        pend.push_back('{2'd0, 16'h000A});
        pend.push_back('{2'd0, 16'h000B});
        pend.push_back('{2'd0, 16'h000C});
        drive_inputs();
        step();
        step();
        sai_pronto = 1'b1;   // full, input offered, consumer ready
        step();
        checks++;
        if (ent_pronto !== 1'b1 || pend.size() != 1 || saidaExtensor !== 32'h0000000B) begin
            failures++;
            $display("FAIL full_pop_only got=r%b held%0d head%08h exp=r1 held1 head0000000B",
                     ent_pronto, pend.size(), saidaExtensor);
        end
        sai_pronto = 1'b0;
        step();               // held input now accepted
        checks++;
        if (ent_pronto !== 1'b0 || pend.size() != 0) begin
            failures++;
            $display("FAIL full_push_next got=r%b held%0d exp=r0 held0", ent_pronto, pend.size());
        end
        drain("full");
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 400; c++) begin
            if (pend.size() < 3 && $urandom_range(99) < 60)
                pend.push_back('{2'($urandom_range(3)), 16'($urandom)});
            if (pend.size() > 0 && !ent_valida) drive_inputs();
            sai_pronto = ($urandom_range(99) < 55);
            step();
        end
        drain("random");
    endtask

    task automatic test_reset_midflight();
        sai_pronto = 1'b0;
        pend.push_back('{2'd1, 16'hAAAA});
        pend.push_back('{2'd1, 16'h5555});
        drive_inputs();
        step();
        step();
        checks++;
        if (sai_valida !== 1'b1 || ent_pronto !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fill got=v%b r%b exp=v1 r0", sai_valida, ent_pronto);
        end
        pend.push_back('{2'd0, 16'h1111});  // offered during reset; must be dropped
        drive_inputs();
        sai_pronto = 1'b1;
        reset = 1'b1;
        step();
        checks++;
        if (sai_valida !== 1'b0 || saidaExtensor !== 32'h0 || contador_ext !== '0 || ent_pronto !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_state got=v%b d%08h c%0d r%b exp=v0 d00000000 c0 r1",
                     sai_valida, saidaExtensor, contador_ext, ent_pronto);
        end
        reset = 1'b0;
        pend.delete();
        drive_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (sai_valida !== 1'b0 || saidaExtensor !== 32'h0) begin
                failures++;
                $display("FAIL reset_mid_stale_%0d got=v%b %08h exp=v0 00000000", i, sai_valida, saidaExtensor);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_full_simultaneous();
        test_random_stream();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_extensor_imediato_pipe
